// File: rtl/decode_buffered_pkg.sv
// Shared decode types: control fields produced by control_unit and the
// forwarding-source record used by the decode stage.
package decode_buffered_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {
    REG_FILE_RS1, ALU1_PC, ALU1_ZERO
  } alu_1_src_t;

  typedef enum logic [1:0] {
    REG_FILE_RS2, ALU2_IMMEDIATE, ALU2_FOUR
  } alu_2_src_t;

  typedef struct packed {
    alu_op_t    alu_op;
    alu_1_src_t alu_1_src;
    alu_2_src_t alu_2_src;
    logic [31:0] immediate;
    logic       reg_we;
    logic       memory_we;
    logic       memory_re;
    logic [2:0] memory_funct3;
    logic       branch;
    logic [2:0] branch_funct3;
    logic       jump;
    logic       ebreak;
    logic       illegal;
  } decoded_instruction_t;

  typedef struct packed {
    logic [4:0]  address;
    logic        valid;
    logic [31:0] data;
  } fwd_source_t;

endpackage

// File: rtl/control_unit.sv
// Combinational RV32I control decoder: opcode/funct fields to ALU source
// selection, immediate, register-write and memory/branch/jump controls.
module control_unit
  import decode_buffered_pkg::*;
(
  input  logic [31:0]          instruction,
  output decoded_instruction_t decoded
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign alt    = instruction[30];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic sub_sra);
    case (f3)
      3'b000:  arith_op = sub_sra ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = sub_sra ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    decoded           = '0;
    decoded.alu_op    = ALU_ADD;
    decoded.alu_1_src = ALU1_ZERO;
    decoded.alu_2_src = ALU2_IMMEDIATE;
    case (opcode)
      OPC_OP_IMM: begin
        // addi has no subtract form, so bit 30 only matters for shifts
        decoded.alu_op    = arith_op(funct3, alt && (funct3 == 3'b101));
        decoded.alu_1_src = REG_FILE_RS1;
        decoded.immediate = imm_i;
        decoded.reg_we    = 1'b1;
      end
      OPC_OP: begin
        decoded.alu_op    = arith_op(funct3, alt);
        decoded.alu_1_src = REG_FILE_RS1;
        decoded.alu_2_src = REG_FILE_RS2;
        decoded.reg_we    = 1'b1;
      end
      OPC_LUI: begin
        decoded.immediate = imm_u;
        decoded.reg_we    = 1'b1;
      end
      OPC_AUIPC: begin
        decoded.alu_1_src = ALU1_PC;
        decoded.immediate = imm_u;
        decoded.reg_we    = 1'b1;
      end
      OPC_JAL: begin
        decoded.alu_1_src = ALU1_PC;
        decoded.alu_2_src = ALU2_FOUR;
        decoded.immediate = imm_j;
        decoded.reg_we    = 1'b1;
        decoded.jump      = 1'b1;
      end
      OPC_JALR: begin
        decoded.alu_1_src = REG_FILE_RS1;
        decoded.immediate = imm_i;
        decoded.reg_we    = 1'b1;
        decoded.jump      = 1'b1;
      end
      OPC_BRANCH: begin
        decoded.alu_op        = ALU_SUB;
        decoded.alu_1_src     = REG_FILE_RS1;
        decoded.alu_2_src     = REG_FILE_RS2;
        decoded.immediate     = imm_b;
        decoded.branch        = 1'b1;
        decoded.branch_funct3 = funct3;
      end
      OPC_LOAD: begin
        decoded.alu_1_src     = REG_FILE_RS1;
        decoded.immediate     = imm_i;
        decoded.reg_we        = 1'b1;
        decoded.memory_re     = 1'b1;
        decoded.memory_funct3 = funct3;
      end
      OPC_STORE: begin
        decoded.alu_1_src     = REG_FILE_RS1;
        decoded.immediate     = imm_s;
        decoded.memory_we     = 1'b1;
        decoded.memory_funct3 = funct3;
      end
      OPC_SYSTEM: decoded.ebreak = (instruction == INSTR_EBREAK);
      default:    decoded.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/forward_select.sv
// Resolves one source operand against the downstream forwarding sources:
// lowest-index match wins, an unfinished match reports pending.
module forward_select #(
  parameter int XLEN       = 32,
  parameter int FWD_STAGES = 3
) (
  input  logic [4:0]                 address,
  input  logic [XLEN-1:0]            reg_data,
  input  logic [5*FWD_STAGES-1:0]    fwd_address,
  input  logic [FWD_STAGES-1:0]      fwd_valid,
  input  logic [XLEN*FWD_STAGES-1:0] fwd_data,
  output logic [XLEN-1:0]            data,
  output logic                       pending
);

  // Walk oldest to youngest so the youngest matching source is applied last.
  always_comb begin
    data    = reg_data;
    pending = 1'b0;
    if (address == 5'd0) begin
      data = '0;
    end else begin
      for (int i = FWD_STAGES - 1; i >= 0; i--) begin
        if (fwd_address[5*i +: 5] == address) begin
          data    = fwd_data[XLEN*i +: XLEN];
          pending = !fwd_valid[i];
        end
      end
    end
  end

endmodule

// File: rtl/decode_buffered.sv
// Decode stage with operand forwarding, hazard stall and a 2-entry
// valid/ready output buffer; counts hazard-stall cycles.
module decode_buffered
  import decode_buffered_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FWD_STAGES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_instruction,
  input  logic                       flush,
  output logic [4:0]                 reg_a_1,
  output logic [4:0]                 reg_a_2,
  input  logic [XLEN-1:0]            reg_rd1,
  input  logic [XLEN-1:0]            reg_rd2,
  input  logic [5*FWD_STAGES-1:0]    fwd_address,
  input  logic [FWD_STAGES-1:0]      fwd_valid,
  input  logic [XLEN*FWD_STAGES-1:0] fwd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output decoded_instruction_t       out_instruction,
  output logic [XLEN-1:0]            out_rs1_data,
  output logic [XLEN-1:0]            out_rs2_data,
  output logic [4:0]                 out_rd_address,
  output logic [31:0]                stall_count
);

  decoded_instruction_t dec_p0;
  logic [XLEN-1:0]      rs1_data_p0, rs2_data_p0;
  logic                 rs1_pend_p0, rs2_pend_p0;
  logic                 rs1_buf_hit, rs2_buf_hit;
  logic                 uses_rs1, uses_rs2, hazard;
  logic                 push, pop, tail;
  logic [4:0]           rd_p0;

  logic [1:0]           count_p1;
  logic [XLEN-1:0]      pc_p1  [2];
  decoded_instruction_t dec_p1 [2];
  logic [XLEN-1:0]      rs1_p1 [2];
  logic [XLEN-1:0]      rs2_p1 [2];
  logic [4:0]           rd_p1  [2];
  logic [31:0]          stall_p1;

  // ---- stage p0: decode and operand resolution ----
  control_unit u_control_unit (
    .instruction (in_instruction),
    .decoded     (dec_p0)
  );

  assign reg_a_1 = in_instruction[19:15];
  assign reg_a_2 = in_instruction[24:20];

  forward_select #(.XLEN(XLEN), .FWD_STAGES(FWD_STAGES)) u_fwd_rs1 (
    .address     (reg_a_1),
    .reg_data    (reg_rd1),
    .fwd_address (fwd_address),
    .fwd_valid   (fwd_valid),
    .fwd_data    (fwd_data),
    .data        (rs1_data_p0),
    .pending     (rs1_pend_p0)
  );

  forward_select #(.XLEN(XLEN), .FWD_STAGES(FWD_STAGES)) u_fwd_rs2 (
    .address     (reg_a_2),
    .reg_data    (reg_rd2),
    .fwd_address (fwd_address),
    .fwd_valid   (fwd_valid),
    .fwd_data    (fwd_data),
    .data        (rs2_data_p0),
    .pending     (rs2_pend_p0)
  );

  // Buffered writers are not forwardable yet; an entry being popped this
  // cycle still counts, which keeps the check off the out_ready path.
  always_comb begin
    rs1_buf_hit = 1'b0;
    rs2_buf_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i < int'(count_p1) && rd_p1[i] != 5'd0) begin
        if (rd_p1[i] == reg_a_1) rs1_buf_hit = 1'b1;
        if (rd_p1[i] == reg_a_2) rs2_buf_hit = 1'b1;
      end
    end
  end

  assign uses_rs1 = (dec_p0.alu_1_src == REG_FILE_RS1);
  assign uses_rs2 = (dec_p0.alu_2_src == REG_FILE_RS2) || dec_p0.memory_we;
  assign hazard   = in_valid && ((uses_rs1 && (rs1_pend_p0 || rs1_buf_hit)) ||
                                 (uses_rs2 && (rs2_pend_p0 || rs2_buf_hit)));

  assign in_ready = (count_p1 < 2'd2) && !hazard;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready;
  assign tail     = count_p1[0] && !pop;
  assign rd_p0    = dec_p0.reg_we ? in_instruction[11:7] : 5'd0;

  // ---- stage p1: output buffer, entry 0 is the head ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_p1 <= 2'd0;
      stall_p1 <= '0;
      for (int i = 0; i < 2; i++) begin
        pc_p1[i]  <= '0;
        dec_p1[i] <= '0;
        rs1_p1[i] <= '0;
        rs2_p1[i] <= '0;
        rd_p1[i]  <= '0;
      end
    end else begin
      if (hazard && !flush && stall_p1 != '1) stall_p1 <= stall_p1 + 32'd1;
      if (flush) begin
        count_p1 <= 2'd0;
      end else begin
        if (pop) begin
          pc_p1[0]  <= pc_p1[1];
          dec_p1[0] <= dec_p1[1];
          rs1_p1[0] <= rs1_p1[1];
          rs2_p1[0] <= rs2_p1[1];
          rd_p1[0]  <= rd_p1[1];
        end
        if (push) begin
          pc_p1[tail]  <= in_pc;
          dec_p1[tail] <= dec_p0;
          rs1_p1[tail] <= rs1_data_p0;
          rs2_p1[tail] <= rs2_data_p0;
          rd_p1[tail]  <= rd_p0;
        end
        count_p1 <= count_p1 + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign out_valid       = (count_p1 != 2'd0);
  assign out_pc          = pc_p1[0];
  assign out_instruction = dec_p1[0];
  assign out_rs1_data    = rs1_p1[0];
  assign out_rs2_data    = rs2_p1[0];
  assign out_rd_address  = rd_p1[0];
  assign stall_count     = stall_p1;

endmodule

// File: tb/tb_decode_buffered.sv
// Randomized and directed bench for decode_buffered against a queue-based
// reference model of the decode buffer.
module tb_decode_buffered;
  import decode_buffered_pkg::*;

  localparam int XLEN = 32;
  localparam int FWD  = 3;
  localparam int K_ADDI = 0, K_ADD = 1, K_LW = 2, K_SW = 3, K_LUI = 4, K_BEQ = 5, K_JAL = 6;

  logic                  clk, rst;
  logic                  in_valid, in_ready, flush, out_valid, out_ready;
  logic [XLEN-1:0]       in_pc, reg_rd1, reg_rd2, out_pc, out_rs1_data, out_rs2_data;
  logic [31:0]           in_instruction, stall_count;
  logic [4:0]            reg_a_1, reg_a_2, out_rd_address;
  logic [5*FWD-1:0]      fwd_address;
  logic [FWD-1:0]        fwd_valid;
  logic [XLEN*FWD-1:0]   fwd_data;
  decoded_instruction_t  out_instruction;

  decode_buffered #(.XLEN(XLEN), .FWD_STAGES(FWD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instruction(in_instruction), .flush(flush), .reg_a_1(reg_a_1), .reg_a_2(reg_a_2),
    .reg_rd1(reg_rd1), .reg_rd2(reg_rd2), .fwd_address(fwd_address), .fwd_valid(fwd_valid),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instruction(out_instruction), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_rd_address(out_rd_address), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign reg_rd1 = rf[reg_a_1];
  assign reg_rd2 = rf[reg_a_2];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        mwe;
    logic        jmp;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_stall;
  logic [31:0] pc_ctr;
  int          checks, errors;

  logic [4:0]  cur_rs1, cur_rs2, cur_rd;
  logic        cur_u1, cur_u2, cur_we, cur_mwe, cur_jmp;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Builds an instruction word from its kind and records what the spec says
  // it reads and writes.
  task automatic set_instr(input int kind, input int rd, input int rs1, input int rs2);
    logic [11:0] imm;
    logic [4:0]  d, s1, s2;
    imm = 12'($urandom_range(0, 4095));
    d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
    cur_u1 = 0; cur_u2 = 0; cur_we = 0; cur_mwe = 0; cur_jmp = 0;
    case (kind)
      K_ADDI: begin in_instruction = {imm, s1, 3'b000, d, 7'b0010011}; cur_u1 = 1; cur_we = 1; end
      K_ADD:  begin in_instruction = {7'b0, s2, s1, 3'b000, d, 7'b0110011}; cur_u1 = 1; cur_u2 = 1; cur_we = 1; end
      K_LW:   begin in_instruction = {imm, s1, 3'b010, d, 7'b0000011}; cur_u1 = 1; cur_we = 1; end
      K_SW:   begin in_instruction = {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'b0100011};
                    cur_u1 = 1; cur_u2 = 1; cur_mwe = 1; end
      K_LUI:  begin in_instruction = {imm, s2, s1[2:0], d, 7'b0110111}; cur_we = 1; end
      K_BEQ:  begin in_instruction = {7'b0, s2, s1, 3'b000, 5'b0, 7'b1100011}; cur_u1 = 1; cur_u2 = 1; end
      default: begin in_instruction = {imm, s2, s1[2:0], d, 7'b1101111}; cur_we = 1; cur_jmp = 1; end
    endcase
    cur_rs1 = in_instruction[19:15];
    cur_rs2 = in_instruction[24:20];
    cur_rd  = cur_we ? d : 5'd0;
    in_pc   = pc_ctr;
  endtask

  // Reference operand rule: x0 reads 0; first matching source in index order
  // supplies data or blocks; any buffered writer of the register also blocks.
  function automatic void resolve(input logic [4:0] a, output logic [31:0] d, output logic pend);
    bit found = 0;
    d = rf[a];
    pend = 0;
    if (a == 5'd0) begin
      d = 0;
      return;
    end
    for (int i = 0; i < FWD; i++) begin
      if (!found && fwd_address[5*i +: 5] == a) begin
        found = 1;
        d = fwd_data[XLEN*i +: XLEN];
        pend = !fwd_valid[i];
      end
    end
    foreach (q[j]) if (q[j].rd == a) pend = 1;
  endfunction

  task automatic step();
    logic [31:0] d1, d2;
    logic p1, p2, hz, rdy, do_push, do_pop;
    exp_t e;
    #1;
    resolve(cur_rs1, d1, p1);
    resolve(cur_rs2, d2, p2);
    hz  = in_valid && ((cur_u1 && p1) || (cur_u2 && p2));
    rdy = (q.size() < 2) && !hz;
    check_val("in_ready", in_ready, rdy);
    if (in_valid && cur_u1) check_val("reg_a_1", reg_a_1, cur_rs1);
    if (in_valid && cur_u2) check_val("reg_a_2", reg_a_2, cur_rs2);
    do_push = in_valid && rdy && !flush;
    do_pop  = (q.size() > 0) && out_ready;
    e = '{pc: pc_ctr, rs1: d1, rs2: d2, rd: cur_rd, mwe: cur_mwe, jmp: cur_jmp};
    @(posedge clk);
    #1;
    if (hz && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    if (do_push) pc_ctr += 4;
    check_val("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_val("out_pc", out_pc, q[0].pc);
      check_val("out_rs1", out_rs1_data, q[0].rs1);
      check_val("out_rs2", out_rs2_data, q[0].rs2);
      check_val("out_rd", out_rd_address, q[0].rd);
      check_val("out_mwe", out_instruction.memory_we, q[0].mwe);
      check_val("out_jump", out_instruction.jump, q[0].jmp);
    end
    check_val("stall_count", stall_count, m_stall);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (n) step();
  endtask

  initial begin
    logic [31:0] s0;
    checks = 0; errors = 0; m_stall = 0; pc_ctr = 32'h1000;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;
    rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    fwd_address = '0; fwd_valid = '0; fwd_data = '0;
    set_instr(K_ADDI, 1, 0, 0);
    repeat (2) @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_stall", stall_count, 0);
    check_val("rst_out_pc", out_pc, 0);
    rst = 0;

    // independent addi stream
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_instr(K_ADDI, 10 + i, 1, 0);
      in_valid = 1;
      step();
    end
    idle(2);
    check_val("stream_stall", stall_count, 0);

    // forward priority: youngest matching source wins
    fwd_address = {5'd5, 5'd0, 5'd5};
    fwd_valid   = 3'b101;
    fwd_data    = {32'h22, 32'h0, 32'h11};
    set_instr(K_ADD, 7, 5, 2);
    in_valid = 1;
    step();
    check_val("fwd_prio", out_rs1_data, 32'h11);
    fwd_address = '0; fwd_valid = '0;
    idle(2);

    // load-use: two stall cycles then forwarded data
    s0 = m_stall;
    fwd_address = {5'd0, 5'd0, 5'd3};
    fwd_data    = {64'h0, 32'h7};
    set_instr(K_ADD, 8, 3, 1);
    in_valid = 1;
    repeat (2) step();
    fwd_valid = 3'b001;
    step();
    check_val("load_use_stall", stall_count, s0 + 2);
    check_val("load_use_data", out_rs1_data, 32'h7);
    fwd_address = '0; fwd_valid = '0;
    idle(2);

    // buffer hazard on x4, x0 operand stays 0
    out_ready = 0;
    set_instr(K_ADDI, 4, 1, 0);
    in_valid = 1;
    step();
    set_instr(K_ADD, 6, 4, 0);
    repeat (3) step();
    out_ready = 1;
    repeat (2) step();
    check_val("buf_haz_rs2_x0", out_rs2_data, 0);
    check_val("buf_haz_rd", out_rd_address, 6);
    idle(2);

    // backpressure until full, then FIFO order
    out_ready = 0;
    set_instr(K_ADDI, 11, 1, 0); in_valid = 1; step();
    set_instr(K_ADDI, 12, 1, 0); step();
    set_instr(K_ADDI, 13, 1, 0); step();
    check_val("full_ready", in_ready, 0);
    in_valid = 0; out_ready = 1;
    step();
    check_val("fifo_order", out_rd_address, 12);
    idle(2);

    // flush beats simultaneous push and pop
    out_ready = 0;
    set_instr(K_ADDI, 14, 1, 0); in_valid = 1; step();
    set_instr(K_ADDI, 15, 1, 0); flush = 1; out_ready = 1; step();
    check_val("flush_valid", out_valid, 0);
    flush = 0;
    idle(1);

    // randomized traffic
    repeat (400) begin
      for (int i = 0; i < FWD; i++) begin
        fwd_address[5*i +: 5]   = 5'($urandom_range(0, 7));
        fwd_valid[i]            = ($urandom_range(0, 3) != 0);
        fwd_data[XLEN*i +: XLEN] = $urandom;
      end
      set_instr($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    fwd_address = '0; fwd_valid = '0;
    idle(3);

    // reset in the middle of a buffer-hazard stall
    out_ready = 0;
    set_instr(K_ADDI, 9, 1, 0); in_valid = 1; step();
    set_instr(K_ADD, 10, 9, 1); step();
    rst = 1;
    #1;
    check_val("rst_mid_valid", out_valid, 0);
    check_val("rst_mid_pc", out_pc, 0);
    check_val("rst_mid_rs1", out_rs1_data, 0);
    check_val("rst_mid_rd", out_rd_address, 0);
    check_val("rst_mid_stall", stall_count, 0);
    q.delete();
    m_stall = 0;
    @(negedge clk);
    rst = 0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
